// File: rtl/intc_pkg.sv
// Shared encodings and constants for the 68000 interrupt-acknowledge sequencer.
package intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_RESPOND = 2'd2
    } iack_state_e;

    typedef enum logic [1:0] {
        MODE_VECTOR   = 2'd0,
        MODE_AUTO     = 2'd1,
        MODE_SPURIOUS = 2'd2
    } iack_mode_e;

    // Levels 7..4 are edge-latched in the controller; level 3 is level-sensitive.
    localparam logic [7:0] CLR_MASK_DEFAULT = 8'hF0;

    localparam logic [2:0] IPL_NONE = 3'd0;
    localparam logic [2:0] IPL_1    = 3'd1;
    localparam logic [2:0] IPL_2    = 3'd2;
    localparam logic [2:0] IPL_3    = 3'd3;
    localparam logic [2:0] IPL_4    = 3'd4;
    localparam logic [2:0] IPL_5    = 3'd5;
    localparam logic [2:0] IPL_6    = 3'd6;
    localparam logic [2:0] IPL_7    = 3'd7;

    function automatic logic [7:0] level_bit(input logic [2:0] lvl);
        return 8'h01 << lvl;
    endfunction

endpackage

// File: rtl/iack_timeout_counter.sv
// Counts cycles spent holding an IACK response; flags the cycle on which the hold limit is reached.
module iack_timeout_counter #(
    parameter int unsigned TO_WIDTH       = 7,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired_c
);

    localparam logic [TO_WIDTH-1:0] LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TO_WIDTH-1:0] count_q;
    logic [TO_WIDTH-1:0] count_d;

    // Saturates at the limit so a late release can never wrap the count.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + TO_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_c = en && !clear && (count_q == LAST);

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 68000 IACK sequencer: picks vectored/autovectored/spurious response and pulses pending clears.
// Optional spurious-IACK counter and its clear input are built when IACK_STATS_EN is defined.
module interrupt_ack_sequencer
    import intc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [7:0]  CLR_MASK       = CLR_MASK_DEFAULT,
    parameter int unsigned TO_WIDTH       = 7
) (
    input  logic       clock,
    input  logic       reset,
`ifdef IACK_STATS_EN
    input  logic       stats_clr,
    output logic [7:0] spurious_count,
`endif
    input  logic       iack_req,
    input  logic [2:0] iack_level,
    input  logic [7:0] pending,
    input  logic [7:0] enable,
    input  logic [7:0] vector_base,
    input  logic [7:0] autovec_mask,
    output logic [7:0] vector_out,
    output logic       vector_oe,
    output logic       dtack_n,
    output logic       vpa_n,
    output logic       berr_n,
    output logic [7:0] pend_clr,
    output logic       busy,
    output logic       timeout_flag
);

    iack_state_e state_q, state_d;
    iack_mode_e  mode_q, mode_d;
    logic [2:0]  lvl_q, lvl_d;
    logic        valid_q, valid_d;
    logic        entry_q, entry_d;
    logic        armed_q, armed_d;

    logic [7:0]  vector_out_q, vector_out_d;
    logic        vector_oe_q, vector_oe_d;
    logic        dtack_n_q, dtack_n_d;
    logic        vpa_n_q, vpa_n_d;
    logic        berr_n_q, berr_n_d;
    logic [7:0]  pend_clr_q, pend_clr_d;
    logic        busy_q, busy_d;
    logic        timeout_flag_q, timeout_flag_d;

    logic        sample_valid;
    logic        resp_on;
    logic        to_clear;
    logic        to_en;
    logic        to_expired;
    logic        unused_vector_lsbs;

    assign unused_vector_lsbs = ^vector_base[2:0];

    assign to_clear = (state_q == ST_SAMPLE);
    assign to_en    = (state_q == ST_RESPOND);

    iack_timeout_counter #(
        .TO_WIDTH      (TO_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (to_clear),
        .en       (to_en),
        .expired_c(to_expired)
    );

    assign sample_valid = (lvl_q != IPL_NONE) && pending[lvl_q] && enable[lvl_q];

    // Strobes stay up only while the CPU holds IACK and the hold limit has not been hit.
    assign resp_on = (state_q == ST_RESPOND) && iack_req && !to_expired;

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        lvl_d          = lvl_q;
        valid_d        = valid_q;
        entry_d        = 1'b0;
        armed_d        = armed_q;
        timeout_flag_d = timeout_flag_q;

        unique case (state_q)
            ST_IDLE: begin
                // A request must be seen low in IDLE before the next one is taken.
                if (!iack_req) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = ST_SAMPLE;
                    lvl_d   = iack_level;
                    armed_d = 1'b0;
                end
            end
            ST_SAMPLE: begin
                if (!iack_req) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESPOND;
                    valid_d = sample_valid;
                    entry_d = 1'b1;
                    if (!sample_valid) begin
                        mode_d = MODE_SPURIOUS;
                    end else if (autovec_mask[lvl_q]) begin
                        mode_d = MODE_AUTO;
                    end else begin
                        mode_d = MODE_VECTOR;
                    end
                end
            end
            ST_RESPOND: begin
                armed_d = 1'b0;
                if (!iack_req) begin
                    state_d = ST_IDLE;
                end else if (to_expired) begin
                    state_d        = ST_IDLE;
                    timeout_flag_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        vector_out_d = 8'h00;
        vector_oe_d  = 1'b0;
        dtack_n_d    = 1'b1;
        vpa_n_d      = 1'b1;
        berr_n_d     = 1'b1;
        pend_clr_d   = 8'h00;
        if (resp_on) begin
            unique case (mode_q)
                MODE_VECTOR: begin
                    vector_out_d = {vector_base[7:3], lvl_q};
                    vector_oe_d  = 1'b1;
                    dtack_n_d    = 1'b0;
                end
                MODE_AUTO:     vpa_n_d  = 1'b0;
                MODE_SPURIOUS: berr_n_d = 1'b0;
                default:       ;
            endcase
            if (entry_q && valid_q) begin
                pend_clr_d = level_bit(lvl_q) & CLR_MASK;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            mode_q         <= MODE_VECTOR;
            lvl_q          <= IPL_NONE;
            valid_q        <= 1'b0;
            entry_q        <= 1'b0;
            armed_q        <= 1'b0;
            vector_out_q   <= 8'h00;
            vector_oe_q    <= 1'b0;
            dtack_n_q      <= 1'b1;
            vpa_n_q        <= 1'b1;
            berr_n_q       <= 1'b1;
            pend_clr_q     <= 8'h00;
            busy_q         <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            lvl_q          <= lvl_d;
            valid_q        <= valid_d;
            entry_q        <= entry_d;
            armed_q        <= armed_d;
            vector_out_q   <= vector_out_d;
            vector_oe_q    <= vector_oe_d;
            dtack_n_q      <= dtack_n_d;
            vpa_n_q        <= vpa_n_d;
            berr_n_q       <= berr_n_d;
            pend_clr_q     <= pend_clr_d;
            busy_q         <= busy_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign vector_out   = vector_out_q;
    assign vector_oe    = vector_oe_q;
    assign dtack_n      = dtack_n_q;
    assign vpa_n        = vpa_n_q;
    assign berr_n       = berr_n_q;
    assign pend_clr     = pend_clr_q;
    assign busy         = busy_q;
    assign timeout_flag = timeout_flag_q;

`ifdef IACK_STATS_EN
    logic [7:0] spurious_count_q, spurious_count_d;

    // Clear beats a same-cycle increment; the count saturates rather than wrapping.
    always_comb begin
        spurious_count_d = spurious_count_q;
        if (stats_clr) begin
            spurious_count_d = 8'h00;
        end else if ((state_q == ST_SAMPLE) && iack_req && !sample_valid
                     && (spurious_count_q != 8'hFF)) begin
            spurious_count_d = spurious_count_q + 8'h01;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            spurious_count_q <= 8'h00;
        end else begin
            spurious_count_q <= spurious_count_d;
        end
    end

    assign spurious_count = spurious_count_q;
`endif

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench for interrupt_ack_sequencer: directed cases plus randomized IACK cycles
// predicted from the acknowledge timing rules.
module tb_interrupt_ack_sequencer;

    localparam int unsigned TIMEOUT = 64;
    localparam logic [7:0]  CLR     = 8'hF0;

    logic       clock = 1'b0;
    logic       reset;
    logic       iack_req;
    logic [2:0] iack_level;
    logic [7:0] pending;
    logic [7:0] enable;
    logic [7:0] vector_base;
    logic [7:0] autovec_mask;
    logic [7:0] vector_out;
    logic       vector_oe;
    logic       dtack_n;
    logic       vpa_n;
    logic       berr_n;
    logic [7:0] pend_clr;
    logic       busy;
    logic       timeout_flag;
`ifdef IACK_STATS_EN
    logic       stats_clr;
    logic [7:0] spurious_count;
`endif

    int   checks = 0;
    int   errors = 0;
    logic tf_model = 1'b0;
    int   sc_model = 0;

    interrupt_ack_sequencer dut (
        .clock         (clock),
        .reset         (reset),
`ifdef IACK_STATS_EN
        .stats_clr     (stats_clr),
        .spurious_count(spurious_count),
`endif
        .iack_req      (iack_req),
        .iack_level    (iack_level),
        .pending       (pending),
        .enable        (enable),
        .vector_base   (vector_base),
        .autovec_mask  (autovec_mask),
        .vector_out    (vector_out),
        .vector_oe     (vector_oe),
        .dtack_n       (dtack_n),
        .vpa_n         (vpa_n),
        .berr_n        (berr_n),
        .pend_clr      (pend_clr),
        .busy          (busy),
        .timeout_flag  (timeout_flag)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic on_vec, input logic on_auto,
                                 input logic on_spur, input logic [7:0] vout,
                                 input logic [7:0] clr, input logic bsy);
        int lows;
        lows = int'(!dtack_n) + int'(!vpa_n) + int'(!berr_n);
        check({tag, ".dtack_n"}, 32'(dtack_n), 32'(!on_vec));
        check({tag, ".vpa_n"}, 32'(vpa_n), 32'(!on_auto));
        check({tag, ".berr_n"}, 32'(berr_n), 32'(!on_spur));
        check({tag, ".vector_oe"}, 32'(vector_oe), 32'(on_vec));
        check({tag, ".vector_out"}, 32'(vector_out), 32'(vout));
        check({tag, ".pend_clr"}, 32'(pend_clr), 32'(clr));
        check({tag, ".busy"}, 32'(busy), 32'(bsy));
        check({tag, ".timeout_flag"}, 32'(timeout_flag), 32'(tf_model));
        check({tag, ".strobe_excl"}, 32'(lows <= 1), 32'd1);
    endtask

    task automatic check_stats(input string tag);
`ifdef IACK_STATS_EN
        check({tag, ".spurious_count"}, 32'(spurious_count), 32'(sc_model));
`endif
    endtask

    // One IACK cycle with iack_req sampled high on edges 0..hold-1 (relative to request).
    // Expected outputs follow the rules: strobes from edge 2, release the edge iack_req is
    // seen low, forced abort after TIMEOUT cycles in RESPOND (entered at edge 1).
    task automatic do_iack(input string tag, input int hold, input logic [2:0] lvl,
                           input logic [7:0] pend, input logic [7:0] en, input logic [7:0] vb,
                           input logic [7:0] av, input bit scramble, input bit rehigh);
        logic       valid, is_auto, is_spur, is_vec, on;
        logic [7:0] vout, clr;
        int         busy_last;
        pending      = pend;
        enable       = en;
        vector_base  = vb;
        autovec_mask = av;
        iack_level   = lvl;
        iack_req     = 1'b1;
        valid   = (lvl != 3'd0) && pend[lvl] && en[lvl];
        is_spur = !valid;
        is_auto = valid && av[lvl];
        is_vec  = valid && !av[lvl];
        if (hold >= 2 && is_spur && sc_model < 255) sc_model++;
        busy_last = ((hold < int'(TIMEOUT) + 1) ? hold : int'(TIMEOUT) + 1) - 1;
        for (int e = 0; e < hold + 3; e++) begin
            @(posedge clock);
            #1;
            on = (e >= 2) && (e <= hold - 1) && (e <= int'(TIMEOUT));
            if (hold > int'(TIMEOUT) + 1 && e >= int'(TIMEOUT) + 1) tf_model = 1'b1;
            vout = (on && is_vec) ? {vb[7:3], lvl} : 8'h00;
            clr  = (e == 2 && on && valid && CLR[lvl]) ? (8'h01 << lvl) : 8'h00;
            check_outputs($sformatf("%s.e%0d", tag, e), on && is_vec, on && is_auto,
                          on && is_spur, vout, clr, e <= busy_last);
            if (scramble && e == 0) iack_level = 3'($urandom);
            if (scramble && e == 1) pending = ~pend;
            if (e == hold - 1) iack_req = 1'b0;
            if (rehigh && e == hold) iack_req = 1'b1;
        end
        check_stats(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        iack_req     = 1'b0;
        iack_level   = 3'd0;
        pending      = 8'h00;
        enable       = 8'h00;
        vector_base  = 8'h00;
        autovec_mask = 8'h00;
`ifdef IACK_STATS_EN
        stats_clr    = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check_stats("reset");
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        do_iack("vec7", 6, 3'd7, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0, 1'b0);
        do_iack("auto3", 5, 3'd3, 8'h08, 8'h08, 8'h40, 8'h08, 1'b0, 1'b0);
        do_iack("spur_pend", 4, 3'd5, 8'hDF, 8'hFF, 8'h88, 8'h00, 1'b0, 1'b0);
        do_iack("spur_en", 4, 3'd5, 8'hFF, 8'hDF, 8'h88, 8'h00, 1'b0, 1'b0);
        do_iack("spur_l0", 4, 3'd0, 8'hFF, 8'hFF, 8'h88, 8'h00, 1'b0, 1'b0);
        do_iack("early1", 1, 3'd7, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0, 1'b0);
        do_iack("early2", 2, 3'd6, 8'h40, 8'h40, 8'h40, 8'h00, 1'b0, 1'b0);
        do_iack("frozen", 5, 3'd4, 8'h10, 8'h10, 8'hA8, 8'h00, 1'b1, 1'b0);
        do_iack("timeout", 100, 3'd6, 8'h40, 8'h40, 8'h20, 8'h00, 1'b0, 1'b0);
        do_iack("after_to", 4, 3'd2, 8'h04, 8'h04, 8'h18, 8'h00, 1'b0, 1'b0);

        // Request raised straight after release must not be taken until seen low in IDLE.
        do_iack("b2b", 4, 3'd7, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        check_outputs("b2b.hold", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        iack_req = 1'b0;
        @(posedge clock);
        #1;
        do_iack("b2b.next", 3, 3'd5, 8'h20, 8'h20, 8'hF8, 8'h20, 1'b0, 1'b0);

        // Reset on the RESPOND entry cycle: reset values next edge, no clear pulse.
        pending     = 8'h80;
        enable      = 8'h80;
        vector_base = 8'h40;
        iack_level  = 3'd7;
        iack_req    = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_mid.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        tf_model = 1'b0;
        sc_model = 0;
        check_outputs("rst_mid", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check_stats("rst_mid");
        reset    = 1'b0;
        iack_req = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        for (int t = 0; t < 40; t++) begin
            int         hold;
            logic [2:0] lvl;
            hold = ($urandom_range(0, 9) == 0) ? 70 : int'($urandom_range(1, 8));
            lvl  = 3'($urandom);
            do_iack($sformatf("rnd%0d", t), hold, lvl, 8'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end

`ifdef IACK_STATS_EN
        stats_clr = 1'b1;
        @(posedge clock);
        #1;
        stats_clr = 1'b0;
        sc_model  = 0;
        check_stats("stats_clr");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
